// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: RISC-V width codes, FSM states,
// the memory mask mode and request legality checking.
package lsu_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MASK_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // Stores only support B/H/W; unsigned codes are load-only.
  function automatic logic lsu_req_error(input logic       write,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic err;
    err = 1'b1;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      F3_BU:   err = write;
      F3_HU:   err = write | addr_lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extends the addressed load lane and merges
// sub-word store data into the previously read memory word.
module lsu_lane_align
  import lsu_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_addr_lo,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic [DATA_WIDTH-1:0] o_store_data
);

  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] HALF_MASK = DATA_WIDTH'(16'hFFFF);

  logic [4:0]            w_bsh;
  logic [4:0]            w_hsh;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_bmask;
  logic [DATA_WIDTH-1:0] w_hmask;

  assign w_bsh   = {i_addr_lo, 3'b000};
  assign w_hsh   = {i_addr_lo[1], 4'b0000};
  assign w_byte  = i_word[w_bsh +: 8];
  assign w_half  = i_word[w_hsh +: 16];
  assign w_bmask = BYTE_MASK << w_bsh;
  assign w_hmask = HALF_MASK << w_hsh;

  // Load result: select lane, then sign- or zero-extend.
  always_comb begin
    o_load_data = {DATA_WIDTH{1'b0}};
    case (i_funct3)
      F3_B:    o_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      F3_W:    o_load_data = i_word;
      F3_BU:   o_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_HU:   o_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: o_load_data = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Store word: replace only the addressed lane of the read-back word.
  always_comb begin
    o_store_data = i_word;
    case (i_funct3)
      F3_B:    o_store_data = (i_word & ~w_bmask) | ((i_wdata & BYTE_MASK) << w_bsh);
      F3_H:    o_store_data = (i_word & ~w_hmask) | ((i_wdata & HALF_MASK) << w_hsh);
      F3_W:    o_store_data = i_wdata;
      default: o_store_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Moore-FSM load/store unit driving a word-wide data memory; sub-word stores
// are done as read-modify-write.
module load_store_unit
  import lsu_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            mem_maskmode,
  output logic                  mem_sext,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  lsu_state_t            r_state;
  lsu_state_t            w_state_nxt;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_err;
  logic                  w_req_err;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_store_data;

  assign w_req_err = lsu_req_error(req_write, req_funct3, req_addr[1:0]);

  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_word       (r_word),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_data (w_store_data)
  );

  // State register plus request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= {DATA_WIDTH{1'b0}};
      r_wdata  <= {DATA_WIDTH{1'b0}};
      r_word   <= {DATA_WIDTH{1'b0}};
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && req_valid) begin
        r_write  <= req_write;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
      end
      if (r_state == ACCESS) begin
        r_word <= mem_read_data;
      end
    end
  end

  // Next-state logic; SW skips the read since it overwrites the whole word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!req_valid) begin
          w_state_nxt = IDLE;
        end else if (w_req_err) begin
          w_state_nxt = RESP;
        end else if (req_write && req_funct3 == F3_W) begin
          w_state_nxt = WRITE;
        end else begin
          w_state_nxt = ACCESS;
        end
      end
      ACCESS:  w_state_nxt = r_write ? WRITE : RESP;
      WRITE:   w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    req_ready      = (r_state == IDLE);
    resp_valid     = (r_state == RESP);
    resp_err       = (r_state == RESP) && r_err;
    resp_rdata     = {DATA_WIDTH{1'b0}};
    mem_read       = (r_state == ACCESS);
    mem_write      = (r_state == WRITE);
    mem_maskmode   = MASK_WORD;
    mem_sext       = 1'b0;
    mem_address    = {DATA_WIDTH{1'b0}};
    mem_write_data = {DATA_WIDTH{1'b0}};
    if (r_state == RESP && !r_write && !r_err) begin
      resp_rdata = w_load_data;
    end else begin
      resp_rdata = {DATA_WIDTH{1'b0}};
    end
    if (r_state == ACCESS || r_state == WRITE) begin
      mem_address = {r_addr[DATA_WIDTH-1:2], 2'b00};
    end else begin
      mem_address = {DATA_WIDTH{1'b0}};
    end
    if (r_state == WRITE) begin
      mem_write_data = w_store_data;
    end else begin
      mem_write_data = {DATA_WIDTH{1'b0}};
    end
  end

endmodule
